// File: rtl/uart_rx_frame_ctrl_if.sv
// Signal bundle between the UART RX frame controller, the serial line side and
// the downstream parity checker. The controller uses the master modport.
interface uart_rx_frame_ctrl_if #(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6
) ();
  logic               rx_in;
  logic [PRESC_W-1:0] prescale;
  logic               parity_en;
  logic               parity_type;
  logic               parity_error;
  logic [DATA_W-1:0]  data_out;
  logic               parity_bit_out;
  logic               par_load;
  logic               par_chk_en;
  logic               data_valid;
  logic               parity_err;
  logic               stop_err;

  modport master (
    input  rx_in, prescale, parity_en, parity_type, parity_error,
    output data_out, parity_bit_out, par_load, par_chk_en,
           data_valid, parity_err, stop_err
  );

  modport slave (
    output rx_in, prescale, parity_en, parity_type, parity_error,
    input  data_out, parity_bit_out, par_load, par_chk_en,
           data_valid, parity_err, stop_err
  );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// UART RX frame controller: start detect with glitch rejection, majority-of-3
// bit sampling, parity checker strobes and per-frame status pulses.
// Optional macro UART_RX_SYNC_EN adds a 2-flop synchronizer on rx_in.
module uart_rx_frame_ctrl #(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  uart_rx_frame_ctrl_if.master bus
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t             state_q, state_d;
  logic               rx;
  logic [PRESC_W-1:0] p_q;
  logic [PRESC_W-1:0] edge_cnt;
  logic [PRESC_W-1:0] half;
  logic [BIT_W-1:0]   bit_cnt;
  logic               samp_p0, samp_p1;
  logic               maj, stop_bit_q, stop_now, par_bad;
  logic               at_early, at_mid, at_late, at_end;
  logic               frame_done, par_load_c;
  logic [DATA_W-1:0]  data_q;
  logic               parity_bit_q;
  logic               data_valid_q, parity_err_q, stop_err_q;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

`ifdef UART_RX_SYNC_EN
  logic sync_p0, sync_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= bus.rx_in;
      sync_p1 <= sync_p0;
    end
  end

  assign rx = sync_p1;
`else
  assign rx = bus.rx_in;
`endif

  assign half     = p_q >> 1;
  assign at_early = (edge_cnt == half - PRESC_W'(1));
  assign at_mid   = (edge_cnt == half);
  assign at_late  = (edge_cnt == half + PRESC_W'(1));
  assign at_end   = (edge_cnt == p_q - PRESC_W'(1));
  assign maj      = maj3(samp_p0, samp_p1, rx);
  // With the smallest prescale the stop decision and the bit end coincide.
  assign stop_now = at_late ? maj : stop_bit_q;
  assign par_bad  = bus.parity_en & bus.parity_error;

  always_comb begin
    state_d    = state_q;
    par_load_c = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      IDLE:   if (!rx) state_d = START;
      START: begin
        if (at_late && maj)  state_d = IDLE;
        else if (at_end)     state_d = DATA;
      end
      DATA:   if (at_end && bit_cnt == LAST_BIT)
                state_d = bus.parity_en ? PARITY : STOP;
      PARITY: if (at_end) begin
                par_load_c = 1'b1;
                state_d    = STOP;
              end
      STOP:   if (at_end) begin
                frame_done = 1'b1;
                state_d    = IDLE;
              end
      default: state_d = IDLE;
    endcase
  end

  // Control: state, bit timing counters and latched prescale
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      edge_cnt <= '0;
      bit_cnt  <= '0;
      p_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        edge_cnt <= (state_d == START) ? PRESC_W'(1) : '0;
        if (state_d == START) p_q <= bus.prescale;
      end else if (state_d == IDLE || at_end) begin
        edge_cnt <= '0;
      end else begin
        edge_cnt <= edge_cnt + PRESC_W'(1);
      end
      if (state_q != DATA) bit_cnt <= '0;
      else if (at_end)     bit_cnt <= bit_cnt + BIT_W'(1);
    end
  end

  // Sampling and captured frame contents
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      samp_p0      <= 1'b0;
      samp_p1      <= 1'b0;
      data_q       <= '0;
      parity_bit_q <= 1'b0;
      stop_bit_q   <= 1'b0;
    end else begin
      if (state_q != IDLE && at_early) samp_p0 <= rx;
      if (state_q != IDLE && at_mid)   samp_p1 <= rx;
      if (at_late) begin
        case (state_q)
          DATA:    data_q[bit_cnt] <= maj;
          PARITY:  parity_bit_q    <= maj;
          STOP:    stop_bit_q      <= maj;
          default: ;
        endcase
      end
    end
  end

  // Status pulses, one cycle after the stop bit ends
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      stop_err_q   <= 1'b0;
    end else begin
      data_valid_q <= frame_done & stop_now & ~par_bad;
      parity_err_q <= frame_done & stop_now & par_bad;
      stop_err_q   <= frame_done & ~stop_now;
    end
  end

  assign bus.data_out       = data_q;
  assign bus.parity_bit_out = parity_bit_q;
  assign bus.par_load       = par_load_c;
  assign bus.par_chk_en     = (state_q == STOP);
  assign bus.data_valid     = data_valid_q;
  assign bus.parity_err     = parity_err_q;
  assign bus.stop_err       = stop_err_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Testbench for uart_rx_frame_ctrl: directed frame table, glitch and reset
// sequences, and randomized frames scored against a frame-level model.
module tb_uart_rx_frame_ctrl;
  localparam int DW = 8;
  localparam int PW = 6;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_frame_ctrl_if #(.DATA_W(DW), .PRESC_W(PW)) bus ();
  uart_rx_frame_ctrl #(.DATA_W(DW), .PRESC_W(PW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Parity checker stand-in: loads on par_load, flags a parity mismatch.
  logic [DW-1:0] chk_d = '0;
  logic          chk_p = 1'b0;
  always @(posedge clk) if (bus.par_load) begin
    chk_d <= bus.data_out;
    chk_p <= bus.parity_bit_out;
  end
  assign bus.parity_error = (^chk_d) ^ chk_p ^ bus.parity_type;

  typedef struct {
    int            cyc;
    logic [2:0]    flg;
    logic [DW-1:0] d;
  } ev_t;

  ev_t act_q[$];
  ev_t exp_q[$];
  int  pl_act[$];
  int  pl_exp[$];
  int  chk_cnt = 0;
  int  exp_chk = 0;

  always @(negedge clk) begin
    if (bus.data_valid | bus.parity_err | bus.stop_err)
      act_q.push_back('{cyc, {bus.data_valid, bus.parity_err, bus.stop_err}, bus.data_out});
    if (bus.par_load)   pl_act.push_back(cyc);
    if (bus.par_chk_en) chk_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] flags_of(input int kind);
    case (kind)
      0:       return 3'b100;
      1:       return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  // Frame-level outcome: 0 = clean, 1 = parity error, 2 = stop error.
  function automatic int model_kind(input logic [DW-1:0] d, input bit pe, input bit pt,
                                    input bit pb, input bit sb);
    int ones;
    if (!sb) return 2;
    ones = $countones(d) + int'(pb);
    if (pe && ((ones % 2) != int'(pt))) return 1;
    return 0;
  endfunction

  task automatic push_exp(input int det, input int p, input bit pe, input int kind,
                          input logic [DW-1:0] d);
    exp_q.push_back('{det + (DW + 2 + int'(pe)) * p - 1, flags_of(kind), d});
    if (pe) pl_exp.push_back(det + (DW + 2) * p - 2);
    exp_chk += p;
  endtask

  // Called just after a rising edge; returns just after the edge where the stop bit ends.
  task automatic send_frame(input int p, input logic [DW-1:0] d, input bit pe, input bit pt,
                            input bit pb, input bit sb, output int det);
    bit bits[$];
    bus.prescale    = PW'(p);
    bus.parity_en   = pe;
    bus.parity_type = pt;
    bus.rx_in       = 1'b0;
    det = cyc + 1;
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(pb);
    bits.push_back(sb);
    for (int i = 0; i < bits.size(); i++) begin
      repeat (p) @(posedge clk);
      #1;
      bus.rx_in = bits[i];
    end
    repeat (p) @(posedge clk);
    #1;
    bus.rx_in = 1'b1;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_npulse"}, act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < act_q.size()) begin
        chk($sformatf("%s_cyc%0d", tag, i),  act_q[i].cyc, exp_q[i].cyc);
        chk($sformatf("%s_flg%0d", tag, i),  act_q[i].flg, exp_q[i].flg);
        chk($sformatf("%s_data%0d", tag, i), act_q[i].d,   exp_q[i].d);
      end
    end
    chk({tag, "_npar_load"}, pl_act.size(), pl_exp.size());
    for (int i = 0; i < pl_exp.size(); i++)
      if (i < pl_act.size()) chk($sformatf("%s_pl_cyc%0d", tag, i), pl_act[i], pl_exp[i]);
    chk({tag, "_chk_en_cycles"}, chk_cnt, exp_chk);
    act_q.delete();
    exp_q.delete();
    pl_act.delete();
    pl_exp.delete();
    chk_cnt = 0;
    exp_chk = 0;
  endtask

  typedef struct {
    int            p;
    logic [DW-1:0] d;
    bit            pe;
    bit            pt;
    bit            pb;
    bit            sb;
    bit            b2b;
    int            kind;
    logic [DW-1:0] exp_d;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int          det;
    int          p, kind;
    logic [DW-1:0] d, a5;
    bit          pe, pt, pb, sb;

    tbl[0] = '{8,  8'hA5, 1, 0, 0, 1, 0, 0, 8'hA5};
    tbl[1] = '{8,  8'hA5, 1, 0, 1, 1, 0, 1, 8'hA5};
    tbl[2] = '{16, 8'h3C, 0, 0, 0, 0, 0, 2, 8'h3C};
    tbl[3] = '{16, 8'h01, 0, 0, 0, 1, 0, 0, 8'h01};
    tbl[4] = '{16, 8'h80, 0, 0, 0, 1, 1, 0, 8'h80};
    tbl[5] = '{6,  8'h00, 1, 1, 1, 1, 0, 0, 8'h00};
    tbl[6] = '{32, 8'hFF, 1, 0, 1, 1, 1, 1, 8'hFF};
    tbl[7] = '{62, 8'h7E, 1, 0, 1, 0, 0, 2, 8'h7E};
    tbl[8] = '{4,  8'hC3, 0, 1, 0, 1, 0, 0, 8'hC3};
    tbl[9] = '{6,  8'h0F, 0, 0, 0, 0, 1, 2, 8'h0F};

    bus.rx_in       = 1'b1;
    bus.prescale    = PW'(8);
    bus.parity_en   = 1'b0;
    bus.parity_type = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {bus.data_out, bus.parity_bit_out, bus.par_load, bus.par_chk_en,
                          bus.data_valid, bus.parity_err, bus.stop_err}, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Directed frame table
    for (int i = 0; i < 10; i++) begin
      if (!tbl[i].b2b) begin
        repeat (3) @(posedge clk);
        #1;
      end
      send_frame(tbl[i].p, tbl[i].d, tbl[i].pe, tbl[i].pt, tbl[i].pb, tbl[i].sb, det);
      push_exp(det, tbl[i].p, tbl[i].pe, tbl[i].kind, tbl[i].exp_d);
    end
    repeat (5) @(posedge clk);
    #1;
    compare_all("table");

    // Start glitch shorter than the decision point, then a clean frame
    bus.prescale  = PW'(8);
    bus.parity_en = 1'b0;
    bus.rx_in     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.rx_in = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("glitch_no_pulse", act_q.size(), 0);
    send_frame(8, 8'h5A, 0, 0, 0, 1, det);
    push_exp(det, 8, 0, 0, 8'h5A);
    repeat (5) @(posedge clk);
    #1;
    compare_all("glitch");

    // Reset during data bit 4, then an odd-parity 0xFF frame
    a5 = 8'hA5;
    bus.prescale    = PW'(8);
    bus.parity_en   = 1'b1;
    bus.parity_type = 1'b0;
    bus.rx_in       = 1'b0;
    for (int i = 0; i < 5; i++) begin
      repeat (8) @(posedge clk);
      #1;
      bus.rx_in = a5[i];
    end
    repeat (3) @(posedge clk);
    #1;
    reset     = 1'b0;
    bus.rx_in = 1'b1;
    #1;
    chk("midframe_reset_outputs", {bus.data_out, bus.parity_bit_out, bus.par_load, bus.par_chk_en,
                                   bus.data_valid, bus.parity_err, bus.stop_err}, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("held_reset_outputs", {bus.data_out, bus.parity_bit_out, bus.par_load, bus.par_chk_en,
                               bus.data_valid, bus.parity_err, bus.stop_err}, 0);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send_frame(8, 8'hFF, 1, 1, 1, 1, det);
    push_exp(det, 8, 1, 0, 8'hFF);
    repeat (5) @(posedge clk);
    #1;
    compare_all("reset");

    // Randomized frames against the frame-level model
    for (int i = 0; i < 20; i++) begin
      p  = 2 * int'($urandom_range(2, 31));
      pe = 1'($urandom_range(0, 1));
      if (pe && p < 6) p = 6;
      pt = 1'($urandom_range(0, 1));
      pb = 1'($urandom_range(0, 1));
      sb = ($urandom_range(0, 3) != 0);
      d  = DW'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1;
      end
      kind = model_kind(d, pe, pt, pb, sb);
      send_frame(p, d, pe, pt, pb, sb, det);
      push_exp(det, p, pe, kind, d);
    end
    repeat (5) @(posedge clk);
    #1;
    compare_all("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
